// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// Defining MEM_ARB_STATS_EN adds the grant/stall statistics outputs.
interface mem_arbiter_if;
    logic        im_req;
    logic [9:0]  im_addr;
    logic [31:0] im_rdata;
    logic        im_ack;
    logic        dm_req;
    logic        dm_write;
    logic [11:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_enable;
    logic        mem_read;
    logic        mem_write;
    logic [11:0] mem_address;
    logic [31:0] mem_in;
    logic [31:0] mem_out;
    logic        busy;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_im_grants;
    logic [15:0] stat_dm_grants;
    logic [15:0] stat_stall_cycles;
`else
    // Statistics outputs are not present in this build.
`endif

    modport slave (
        input  im_req, im_addr, dm_req, dm_write, dm_addr, dm_wdata, mem_out,
        output im_rdata, im_ack, dm_rdata, dm_ack, mem_enable, mem_read, mem_write,
        output mem_address, mem_in, busy
`ifdef MEM_ARB_STATS_EN
        , output stat_im_grants, stat_dm_grants, stat_stall_cycles
`endif
    );

    modport master (
        output im_req, im_addr, dm_req, dm_write, dm_addr, dm_wdata, mem_out,
        input  im_rdata, im_ack, dm_rdata, dm_ack, mem_enable, mem_read, mem_write,
        input  mem_address, mem_in, busy
`ifdef MEM_ARB_STATS_EN
        , input stat_im_grants, stat_dm_grants, stat_stall_cycles
`endif
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data access.
// Data has priority; a starvation counter forces fetch through. MEM_ARB_STATS_EN adds counters.
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [11:0] IM_BASE      = 12'h000
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [3:0] LatInit   = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic [3:0]  lat_q, lat_d;
    logic [3:0]  starve_q, starve_d;
    logic        gnt_im_q, gnt_im_d;
    logic        write_q, write_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] im_rdata_q, im_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;

    logic force_im, grant_im, grant_dm;

    always_comb begin
        force_im = bus.im_req && (starve_q == StarveMax);
        grant_dm = (state_q == StIdle) && bus.dm_req && !force_im;
        grant_im = (state_q == StIdle) && bus.im_req && !grant_dm;
    end

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        starve_d   = starve_q;
        gnt_im_d   = gnt_im_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        im_rdata_d = im_rdata_q;
        dm_rdata_d = dm_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (grant_dm) begin
                    gnt_im_d = 1'b0;
                    write_d  = bus.dm_write;
                    addr_d   = bus.dm_addr;
                    wdata_d  = bus.dm_wdata;
                    lat_d    = LatInit;
                    state_d  = StAccess;
                end else if (grant_im) begin
                    gnt_im_d = 1'b1;
                    write_d  = 1'b0;
                    addr_d   = IM_BASE + {2'b00, bus.im_addr};
                    wdata_d  = '0;
                    lat_d    = LatInit;
                    state_d  = StAccess;
                end
                // Only DM grants that bypass a waiting fetch count toward starvation.
                if (!bus.im_req || grant_im) begin
                    starve_d = '0;
                end else if (grant_dm && starve_q != StarveMax) begin
                    starve_d = starve_q + 4'd1;
                end
            end
            StAccess: begin
                if (lat_q == 4'd0) begin
                    state_d = StResp;
                    if (gnt_im_q) begin
                        im_rdata_d = bus.mem_out;
                    end else if (!write_q) begin
                        dm_rdata_d = bus.mem_out;
                    end
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            lat_q      <= '0;
            starve_q   <= '0;
            gnt_im_q   <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            im_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            starve_q   <= starve_d;
            gnt_im_q   <= gnt_im_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            im_rdata_q <= im_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    logic in_access, in_resp;
    assign in_access = (state_q == StAccess);
    assign in_resp   = (state_q == StResp);

    assign bus.mem_enable  = in_access;
    assign bus.mem_read    = in_access && !write_q;
    assign bus.mem_write   = in_access && write_q;
    assign bus.mem_address = in_access ? addr_q : 12'h000;
    assign bus.mem_in      = (in_access && write_q) ? wdata_q : 32'h0;
    assign bus.im_ack      = in_resp && gnt_im_q;
    assign bus.dm_ack      = in_resp && !gnt_im_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.im_rdata    = im_rdata_q;
    assign bus.dm_rdata    = dm_rdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_im_q, stat_dm_q, stat_stall_q;
    logic        im_waiting, dm_waiting;

    // A requester is in service from its first ACCESS cycle through its RESP cycle.
    assign im_waiting = bus.im_req && !grant_im && !((state_q != StIdle) && gnt_im_q);
    assign dm_waiting = bus.dm_req && !grant_dm && !((state_q != StIdle) && !gnt_im_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_im_q    <= '0;
            stat_dm_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            if (grant_im && stat_im_q != 16'hFFFF) begin
                stat_im_q <= stat_im_q + 16'd1;
            end
            if (grant_dm && stat_dm_q != 16'hFFFF) begin
                stat_dm_q <= stat_dm_q + 16'd1;
            end
            if ((im_waiting || dm_waiting) && stat_stall_q != 16'hFFFF) begin
                stat_stall_q <= stat_stall_q + 16'd1;
            end
        end
    end

    assign bus.stat_im_grants    = stat_im_q;
    assign bus.stat_dm_grants    = stat_dm_q;
    assign bus.stat_stall_cycles = stat_stall_q;
`else
    // Statistics counters are not built.
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 1 / base 0, latency 3 / base F00) share
// directed stimulus; a transaction-level model predicts every output on every cycle.
module tb_mem_arbiter;
    localparam int          StarveLim = 4;
    localparam int          LatA      = 1;
    localparam int          LatB      = 3;
    localparam logic [11:0] BaseA     = 12'h000;
    localparam logic [11:0] BaseB     = 12'hF00;

    logic        clk;
    logic        rst;
    logic        im_req [2];
    logic        dm_req [2];
    logic [9:0]  im_addr;
    logic        dm_write;
    logic [11:0] dm_addr;
    logic [31:0] dm_wdata;
    bit          hold;

    int checks;
    int errors;

    function automatic logic [31:0] data_of(input logic [11:0] a);
        if (a == 12'h005) return 32'hDEADBEEF;
        return {20'hCAFE0, a};
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? LatA : LatB;
    endfunction

    function automatic logic [11:0] base_of(input int i);
        return (i == 0) ? BaseA : BaseB;
    endfunction

    mem_arbiter_if ifa ();
    mem_arbiter_if ifb ();

    assign ifa.im_req   = im_req[0];
    assign ifa.dm_req   = dm_req[0];
    assign ifa.im_addr  = im_addr;
    assign ifa.dm_write = dm_write;
    assign ifa.dm_addr  = dm_addr;
    assign ifa.dm_wdata = dm_wdata;
    assign ifa.mem_out  = data_of(ifa.mem_address);
    assign ifb.im_req   = im_req[1];
    assign ifb.dm_req   = dm_req[1];
    assign ifb.im_addr  = im_addr;
    assign ifb.dm_write = dm_write;
    assign ifb.dm_addr  = dm_addr;
    assign ifb.dm_wdata = dm_wdata;
    assign ifb.mem_out  = data_of(ifb.mem_address);

    mem_arbiter #(.MEM_LATENCY(LatA), .STARVE_LIMIT(StarveLim), .IM_BASE(BaseA)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    mem_arbiter #(.MEM_LATENCY(LatB), .STARVE_LIMIT(StarveLim), .IM_BASE(BaseB)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: at most one transaction in flight per instance, timed from its first ACCESS cycle.
    bit          m_active [2];
    bit          m_is_im  [2];
    bit          m_write  [2];
    logic [11:0] m_addr   [2];
    logic [31:0] m_wdata  [2];
    logic [31:0] m_ird    [2];
    logic [31:0] m_drd    [2];
    int          m_start  [2];
    int          m_starve [2];
    bit          rst_prev;
    int          cyc;

    // Observations of the DUTs, used by the hand-computed checks.
    int          ack_cyc    [2];
    int          ack_cnt    [2];
    int          en_cnt     [2];
    logic [11:0] first_addr [2];
    bit          first_seen [2];
    bit          iack_seen  [2];
    bit          dack_seen  [2];
    bit          busy_seen  [2];
    string       ack_str    [2];
    int          req_cyc;

    task automatic chk(input int i, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s at cycle %0d: got %0h expected %0h", i, name, cyc, act, exp);
        end
    endtask

    task automatic chk_str(input int i, input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %s expected %s", i, name, act, exp);
        end
    endtask

    task automatic compare();
        logic        o_en [2], o_rd [2], o_wr [2], o_iack [2], o_dack [2], o_busy [2];
        logic [11:0] o_addr [2];
        logic [31:0] o_in [2], o_ird [2], o_drd [2];
        logic        e_en, e_rd, e_wr, e_iack, e_dack, e_busy;
        logic [11:0] e_addr;
        logic [31:0] e_in;
        o_en[0] = ifa.mem_enable;  o_en[1] = ifb.mem_enable;
        o_rd[0] = ifa.mem_read;    o_rd[1] = ifb.mem_read;
        o_wr[0] = ifa.mem_write;   o_wr[1] = ifb.mem_write;
        o_iack[0] = ifa.im_ack;    o_iack[1] = ifb.im_ack;
        o_dack[0] = ifa.dm_ack;    o_dack[1] = ifb.dm_ack;
        o_busy[0] = ifa.busy;      o_busy[1] = ifb.busy;
        o_addr[0] = ifa.mem_address; o_addr[1] = ifb.mem_address;
        o_in[0] = ifa.mem_in;      o_in[1] = ifb.mem_in;
        o_ird[0] = ifa.im_rdata;   o_ird[1] = ifb.im_rdata;
        o_drd[0] = ifa.dm_rdata;   o_drd[1] = ifb.dm_rdata;
        for (int i = 0; i < 2; i++) begin
            if (rst_prev) begin
                m_active[i] = 1'b0;
                m_starve[i] = 0;
                m_ird[i]    = '0;
                m_drd[i]    = '0;
            end
            e_en = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_iack = 1'b0; e_dack = 1'b0;
            e_busy = 1'b0; e_addr = '0; e_in = '0;
            if (m_active[i]) begin
                e_busy = 1'b1;
                if (cyc < m_start[i] + lat_of(i)) begin
                    e_en   = 1'b1;
                    e_rd   = !m_write[i];
                    e_wr   = m_write[i];
                    e_addr = m_addr[i];
                    e_in   = m_write[i] ? m_wdata[i] : 32'h0;
                end else if (m_is_im[i]) begin
                    e_iack   = 1'b1;
                    m_ird[i] = data_of(m_addr[i]);
                end else begin
                    e_dack = 1'b1;
                    if (!m_write[i]) m_drd[i] = data_of(m_addr[i]);
                end
            end
            chk(i, "mem_enable", 32'(o_en[i]), 32'(e_en));
            chk(i, "mem_read", 32'(o_rd[i]), 32'(e_rd));
            chk(i, "mem_write", 32'(o_wr[i]), 32'(e_wr));
            chk(i, "mem_address", 32'(o_addr[i]), 32'(e_addr));
            chk(i, "mem_in", o_in[i], e_in);
            chk(i, "im_ack", 32'(o_iack[i]), 32'(e_iack));
            chk(i, "dm_ack", 32'(o_dack[i]), 32'(e_dack));
            chk(i, "busy", 32'(o_busy[i]), 32'(e_busy));
            chk(i, "im_rdata", o_ird[i], m_ird[i]);
            chk(i, "dm_rdata", o_drd[i], m_drd[i]);

            if (o_en[i]) begin
                en_cnt[i]++;
                if (!first_seen[i]) begin
                    first_seen[i] = 1'b1;
                    first_addr[i] = o_addr[i];
                end
            end
            iack_seen[i] = o_iack[i];
            dack_seen[i] = o_dack[i];
            busy_seen[i] = o_busy[i];
            if (o_iack[i] || o_dack[i]) begin
                ack_cnt[i]++;
                ack_cyc[i] = cyc;
                if (o_iack[i]) ack_str[i] = {ack_str[i], "I"};
                else ack_str[i] = {ack_str[i], "D"};
            end

            if (!rst) begin
                if (m_active[i]) begin
                    if (cyc == m_start[i] + lat_of(i)) m_active[i] = 1'b0;
                end else if (dm_req[i] && !(im_req[i] && m_starve[i] == StarveLim)) begin
                    m_active[i] = 1'b1;
                    m_start[i]  = cyc + 1;
                    m_is_im[i]  = 1'b0;
                    m_write[i]  = dm_write;
                    m_addr[i]   = dm_addr;
                    m_wdata[i]  = dm_wdata;
                    if (!im_req[i]) m_starve[i] = 0;
                    else if (m_starve[i] < StarveLim) m_starve[i] = m_starve[i] + 1;
                end else if (im_req[i]) begin
                    m_active[i] = 1'b1;
                    m_start[i]  = cyc + 1;
                    m_is_im[i]  = 1'b1;
                    m_write[i]  = 1'b0;
                    m_addr[i]   = 12'((int'(base_of(i)) + int'(im_addr)) % 4096);
                    m_wdata[i]  = '0;
                    m_starve[i] = 0;
                end else begin
                    m_starve[i] = 0;
                end
            end
        end
        rst_prev = rst;
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (!hold) begin
                if (iack_seen[i]) im_req[i] = 1'b0;
                if (dack_seen[i]) dm_req[i] = 1'b0;
            end
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 2; i++) begin
            ack_cnt[i]    = 0;
            en_cnt[i]     = 0;
            first_seen[i] = 1'b0;
            first_addr[i] = '0;
            ack_str[i]    = "";
        end
        req_cyc = cyc;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((im_req[0] || dm_req[0] || im_req[1] || dm_req[1] || busy_seen[0] ||
                busy_seen[1]) && n < budget) begin
            step();
            n++;
        end
        chk(0, "finished_in_budget", 32'(n < budget), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        rst_prev = 1'b1;
        hold = 1'b0;
        rst = 1'b1;
        im_addr = '0;
        dm_write = 1'b0;
        dm_addr = '0;
        dm_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            im_req[i] = 1'b0;
            dm_req[i] = 1'b0;
            m_active[i] = 1'b0;
            m_starve[i] = 0;
            ack_cyc[i] = 0;
            iack_seen[i] = 1'b0;
            dack_seen[i] = 1'b0;
            busy_seen[i] = 1'b0;
        end
        clear_obs();
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Instruction fetch of word 5.
        clear_obs();
        im_addr = 10'h005;
        im_req[0] = 1'b1; im_req[1] = 1'b1;
        run_until_idle(40);
        chk(0, "t1_ack_latency", ack_cyc[0] - req_cyc, 2);
        chk(1, "t1_ack_latency", ack_cyc[1] - req_cyc, 4);
        chk(0, "t1_address", 32'(first_addr[0]), 32'h005);
        chk(1, "t1_address", 32'(first_addr[1]), 32'hF05);
        chk(0, "t1_im_rdata", ifa.im_rdata, 32'hDEADBEEF);
        chk(1, "t1_im_rdata", ifb.im_rdata, 32'hCAFE0F05);

        // Data write: no read data update.
        clear_obs();
        dm_write = 1'b1; dm_addr = 12'h800; dm_wdata = 32'h12345678;
        dm_req[0] = 1'b1; dm_req[1] = 1'b1;
        run_until_idle(40);
        chk(0, "t2_enable_cycles", en_cnt[0], 1);
        chk(1, "t2_enable_cycles", en_cnt[1], 3);
        chk(0, "t2_ack_count", ack_cnt[0], 1);
        chk(1, "t2_ack_latency", ack_cyc[1] - req_cyc, 4);
        chk(0, "t2_dm_rdata", ifa.dm_rdata, 32'h0);
        chk(1, "t2_dm_rdata", ifb.dm_rdata, 32'h0);

        // Data read.
        clear_obs();
        dm_write = 1'b0; dm_addr = 12'h123; dm_wdata = 32'hFFFFFFFF;
        dm_req[0] = 1'b1; dm_req[1] = 1'b1;
        run_until_idle(40);
        chk(0, "t3_ack_latency", ack_cyc[0] - req_cyc, 2);
        chk(1, "t3_ack_latency", ack_cyc[1] - req_cyc, 4);
        chk(1, "t3_enable_cycles", en_cnt[1], 3);
        chk(0, "t3_dm_rdata", ifa.dm_rdata, 32'hCAFE0123);
        chk(1, "t3_dm_rdata", ifb.dm_rdata, 32'hCAFE0123);

        // Fetch address wraps past the top of memory when offset by the base.
        clear_obs();
        im_addr = 10'h200;
        im_req[0] = 1'b1; im_req[1] = 1'b1;
        run_until_idle(40);
        chk(0, "t4_address", 32'(first_addr[0]), 32'h200);
        chk(1, "t4_address", 32'(first_addr[1]), 32'h100);
        chk(1, "t4_im_rdata", ifb.im_rdata, 32'hCAFE0100);

        // Both requesters held: four DM grants then one forced IM grant.
        clear_obs();
        hold = 1'b1;
        im_addr = 10'h011; dm_addr = 12'h040; dm_write = 1'b0;
        im_req[0] = 1'b1; im_req[1] = 1'b1; dm_req[0] = 1'b1; dm_req[1] = 1'b1;
        repeat (52) step();
        for (int i = 0; i < 2; i++) begin
            im_req[i] = 1'b0;
            dm_req[i] = 1'b0;
        end
        hold = 1'b0;
        run_until_idle(40);
        chk_str(0, "t5_grant_order", ack_str[0].substr(0, 9), "DDDDIDDDDI");
        chk_str(1, "t5_grant_order", ack_str[1], "DDDDIDDDDID");

        // Reset during the second ACCESS cycle of the latency-3 instance.
        clear_obs();
        im_addr = 10'h007;
        im_req[0] = 1'b1; im_req[1] = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        im_req[0] = 1'b0; im_req[1] = 1'b0;
        chk(1, "t6_busy_after_rst", 32'(ifb.busy), 32'd0);
        chk(1, "t6_enable_after_rst", 32'(ifb.mem_enable), 32'd0);
        chk(1, "t6_address_after_rst", 32'(ifb.mem_address), 32'd0);
        chk(1, "t6_im_rdata_after_rst", ifb.im_rdata, 32'h0);
        repeat (3) step();
        chk(1, "t6_no_ack", ack_cnt[1], 0);

        clear_obs();
        im_addr = 10'h009;
        im_req[0] = 1'b1; im_req[1] = 1'b1;
        run_until_idle(40);
        chk(0, "t6_retry_latency", ack_cyc[0] - req_cyc, 2);
        chk(1, "t6_retry_latency", ack_cyc[1] - req_cyc, 4);
        chk(0, "t6_retry_rdata", ifa.im_rdata, 32'hCAFE0009);
        chk(1, "t6_retry_rdata", ifb.im_rdata, 32'hCAFE0F09);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (10-bit word address) and the data-access requester (12-bit address).
- Sits between the CPU top and the memory macro, replacing separate instruction-memory and data-memory ports.
- Sequences each access through a fixed-latency memory using a req/ack handshake.
- Fixed priority favours data; a starvation counter guarantees fetch progress.

Parameters:
MEM_LATENCY, 1, memory access cycles per transaction (legal 1..15)
STARVE_LIMIT, 4, consecutive DM grants with IM pending before IM is forced (legal 1..15)
IM_BASE, 12'h000, base added to the zero-extended im_addr to form the memory address

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
im_req  in  1  fetch request, held until im_ack
im_addr  in  10  fetch word address
im_rdata  out  32  fetched instruction, valid with im_ack, held until next im_ack
im_ack  out  1  one-cycle completion pulse
dm_req  in  1  data request, held until dm_ack
dm_write  in  1  1 = write, 0 = read
dm_addr  in  12  data address
dm_wdata  in  32  write data
dm_rdata  out  32  read data, valid with dm_ack on reads, held until next DM read ack
dm_ack  out  1  one-cycle completion pulse
mem_enable  out  1  memory enable
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  12  memory address
mem_in  out  32  memory write data
mem_out  in  32  memory read data
busy  out  1  high in ACCESS and RESP

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE; all outputs 0; latency counter and starvation counter 0.
  - Reset mid-transaction aborts it: no ack is issued and the memory strobes are low from the cycle after the reset edge.
- State IDLE:
  - Arbitrate on the current req levels.
  - DM wins when dm_req=1, unless starve_cnt==STARVE_LIMIT and im_req=1, in which case IM wins.
  - The winner's address, wdata and write flag are latched at the clock edge; go to ACCESS with lat_cnt=MEM_LATENCY-1.
  - No req: stay in IDLE with strobes low.
- State ACCESS:
  - mem_enable=1.
  - mem_read=1 for an IM access or a DM read; mem_write=1 for a DM write.
  - mem_address = latched address; for IM it is (IM_BASE + {2'b0, im_addr}) mod 4096.
  - mem_in = latched wdata for DM writes, otherwise 0.
  - lat_cnt decrements each cycle.
  - When lat_cnt==0: for reads, capture mem_out into the granted port's rdata register at that edge; go to RESP.
- State RESP:
  - Strobes low; granted port's ack=1 for exactly one cycle; return to IDLE.
  - Req inputs are ignored in this state.
- Latency: a req first high in IDLE cycle T gets its ack in cycle T+MEM_LATENCY+1. Back-to-back transactions cost MEM_LATENCY+2 cycles each.
- Requesters deassert req at the edge that ends the ack cycle. A req high in the IDLE cycle after an ack is a new request.
- Req inputs and addresses are sampled only in IDLE; changes during ACCESS have no effect.
- Starvation counter:
  - Increments on each DM grant while im_req=1, saturating at STARVE_LIMIT.
  - Clears on any IM grant, and in any IDLE cycle with im_req=0.
- Simultaneous im_req and dm_req with starve_cnt<STARVE_LIMIT: DM is granted; the IM request stays pending.
- The non-granted ack is always 0. im_ack and dm_ack are never high in the same cycle.
- DM write: dm_ack is issued; dm_rdata is unchanged.

Optional Feature:
- MEM_ARB_STATS_EN defined adds three outputs:
  - stat_im_grants [15:0]: count of IM grants.
  - stat_dm_grants [15:0]: count of DM grants.
  - stat_stall_cycles [15:0]: count of cycles where any req=1 and that requester is neither granted this cycle nor in service.
  - All three saturate at 16'hFFFF and clear on rst.
- Undefined: the stat ports and counters are absent; all other behaviour is identical.

Test Plan:
- MEM_LATENCY=1: im_req with im_addr=10'h005 and mem_out=32'hDEADBEEF during ACCESS -> mem_address=12'h005 in cycle 1; im_ack=1 with im_rdata=32'hDEADBEEF in cycle 2.
- DM write dm_addr=12'h800, dm_wdata=32'h12345678 -> mem_write=1, mem_in=32'h12345678 for MEM_LATENCY cycles; dm_ack one cycle; dm_rdata unchanged.
- im_req and dm_req both held continuously, STARVE_LIMIT=4 -> grant order DM,DM,DM,DM,IM, then repeats.
- MEM_LATENCY=3, DM read: dm_ack exactly 4 cycles after dm_req first high; mem_enable high for exactly 3 cycles.
- rst asserted in the second ACCESS cycle -> no ack; all outputs 0 the following cycle; a subsequent im_req completes normally.
- IM_BASE=12'hF00, im_addr=10'h200 -> mem_address=12'h100 (wrap).
